// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous pixel SRAM between VGA scan-out and a pixel writer.
// Latency: the pixel for the position presented at cycle t appears on pix_data at t+2. A buffered write
//          reaches the SRAM no earlier than the next cycle, and only in slots the display does not need.
// Backpressure: wr_ready = FIFO not full. It comes from registered occupancy only, with no path from wr_valid.
// Ports: clk/reset (async, active-low); xpos/ypos raster position in; pix_data out;
//        wr_valid/wr_ready/wr_addr/wr_data write channel; wr_level occupancy; wr_err sticky drop flag;
//        mem_addr/mem_we/mem_wdata SRAM command (combinational); mem_rdata SRAM read data in.

// Generic synchronous FIFO with a show-ahead head. The caller guarantees no push when full
// and no pop when empty.
module vga_fb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   cnt;

  // Storage needs no reset: only entries counted by cnt are ever consumed.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_dat = store[rd_ptr];
  assign level    = cnt;
endmodule

module vga_fb_arbiter #(
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int AW         = 17,
  parameter int DW         = 24,
  parameter int H_DISPLAY  = 640,
  parameter int V_DISPLAY  = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    xpos,
  input  logic [9:0]                    ypos,
  output logic [DW-1:0]                 pix_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [DW-1:0]                 wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   wr_level,
  output logic                          wr_err,
  output logic [AW-1:0]                 mem_addr,
  output logic                          mem_we,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata
);
  localparam int              LW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0]      H_END   = 10'(H_DISPLAY);
  localparam logic [9:0]      V_END   = 10'(V_DISPLAY);
  localparam logic [AW:0]     FB_SIZE = (AW+1)'(FB_W * FB_H);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_ent_t;

  logic          active;
  logic          disp_slot;
  logic [AW-1:0] disp_addr;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          head_in_range;
  logic          wr_issue;
  wr_ent_t       push_ent;
  wr_ent_t       head_ent;

  logic          s1_disp;
  logic          s1_active;
  logic          s2_active;
  logic [DW-1:0] pix_hold;
  logic          err_q;

  // Even visible columns own the SRAM; every other cycle is free for a write.
  assign active    = (xpos < H_END) && (ypos < V_END);
  assign disp_slot = active && !xpos[0];
  // Dropping bit 0 of both coordinates gives the 2x2 pixel doubling.
  assign disp_addr = AW'(ypos[9:1]) * AW'(FB_W) + AW'(xpos[9:1]);

  assign push_ent.addr = wr_addr;
  assign push_ent.data = wr_data;
  assign wr_ready      = wr_level < LW'(FIFO_DEPTH);
  assign fifo_push     = wr_valid && wr_ready;
  assign fifo_empty    = (wr_level == '0);
  assign fifo_pop      = !disp_slot && !fifo_empty;
  assign head_in_range = {1'b0, head_ent.addr} < FB_SIZE;
  // An out-of-range head is still popped so one bad write cannot stall the queue.
  assign wr_issue      = fifo_pop && head_in_range;

  vga_fb_fifo #(
    .W     ($bits(wr_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (push_ent),
    .pop      (fifo_pop),
    .head_dat (head_ent),
    .level    (wr_level)
  );

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (disp_slot) begin
      mem_addr = disp_addr;
    end else if (wr_issue) begin
      mem_addr  = head_ent.addr;
      mem_we    = 1'b1;
      mem_wdata = head_ent.data;
    end
  end

  // Read pipeline: SRAM data for a display slot arrives one cycle later and is held
  // across the following odd column, which gives the horizontal doubling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_disp   <= 1'b0;
      s1_active <= 1'b0;
      s2_active <= 1'b0;
      pix_hold  <= '0;
      err_q     <= 1'b0;
    end else begin
      s1_disp   <= disp_slot;
      s1_active <= active;
      s2_active <= s1_active;
      if (s1_disp) pix_hold <= mem_rdata;
      if (fifo_pop && !head_in_range) err_q <= 1'b1;
    end
  end

  assign pix_data = s2_active ? pix_hold : '0;
  assign wr_err   = err_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized raster/write stimulus, checked every cycle against a queue-based model.
// The model tracks the pending write queue, the frame-buffer contents and the per-cycle raster history.
// Directed phases cover reset, doubling, full FIFO, blanking drain, bad addresses and the raster edge.
module tb_vga_fb_arbiter;
  localparam int FB_W    = 320;
  localparam int FB_SIZE = 76800;
  localparam int AW      = 17;
  localparam int DW      = 24;
  localparam int HN      = 16384;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    xpos, ypos;
  logic [DW-1:0] pix_data;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    wr_level;
  logic          wr_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .xpos      (xpos),
    .ypos      (ypos),
    .pix_data  (pix_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_level  (wr_level),
    .wr_err    (wr_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // SRAM attached to the DUT: read data valid the cycle after the address is sampled.
  logic [DW-1:0] sram [131072];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  // Reference model state
  wr_t           q[$];
  logic [DW-1:0] fb [FB_SIZE];
  bit            act_h [HN];
  bit            fv    [HN];
  logic [DW-1:0] fval  [HN];
  logic [DW-1:0] pix_log [HN];
  int            cyc = 0;
  int            last_rst = -1;
  bit            m_err, pushed, run, full_seen;
  int            we_cnt;
  int            n_cmp, n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Compare process: outputs are checked at the falling edge, then the model advances
  // by what the next rising edge must do.
  always @(negedge clk) begin
    int            sz, p;
    bit            act, disp;
    logic [DW-1:0] exp_pix;
    wr_t           h, nw;
    if (run && cyc < HN) begin
      sz = q.size();
      pushed = 0;
      if (mem_we) we_cnt++;
      if (!reset) begin
        q.delete();
        m_err = 0;
        last_rst = cyc;
        act_h[cyc] = 0;
        fv[cyc] = 0;
        chk("rst_level", 32'(wr_level), 0);
        chk("rst_ready", 32'(wr_ready), 1);
        chk("rst_err", 32'(wr_err), 0);
        chk("rst_pix", 32'(pix_data), 0);
        chk("rst_we", 32'(mem_we), 0);
      end else begin
        act  = (int'(xpos) < 640) && (int'(ypos) < 480);
        disp = act && (int'(xpos) % 2 == 0);
        act_h[cyc] = act;
        fv[cyc] = disp;
        if (disp) fval[cyc] = fb[(int'(ypos) / 2) * FB_W + int'(xpos) / 2];
        // Pixel shown now: position two cycles ago, value from the latest fetch at or before it.
        exp_pix = '0;
        p = cyc - 2;
        if (p > last_rst && act_h[p]) begin
          for (int k = p; k > last_rst; k--) begin
            if (fv[k]) begin
              exp_pix = fval[k];
              break;
            end
          end
        end
        chk("pix_data", 32'(pix_data), 32'(exp_pix));
        chk("wr_level", 32'(wr_level), 32'(sz));
        chk("wr_ready", 32'(wr_ready), 32'(sz < 4));
        chk("wr_err", 32'(wr_err), 32'(m_err));
        if (disp) begin
          chk("rd_we", 32'(mem_we), 0);
          chk("rd_addr", 32'(mem_addr), 32'((int'(ypos) / 2) * FB_W + int'(xpos) / 2));
          chk("rd_wdata", 32'(mem_wdata), 0);
        end else if (sz == 0) begin
          chk("idle_we", 32'(mem_we), 0);
          chk("idle_addr", 32'(mem_addr), 0);
          chk("idle_wdata", 32'(mem_wdata), 0);
        end else begin
          h = q.pop_front();
          if (int'(h.a) < FB_SIZE) begin
            chk("wr_we", 32'(mem_we), 1);
            chk("wr_addr", 32'(mem_addr), 32'(h.a));
            chk("wr_wdata", 32'(mem_wdata), 32'(h.d));
            fb[h.a] = h.d;
          end else begin
            chk("drop_we", 32'(mem_we), 0);
            m_err = 1;
          end
        end
        if (wr_valid && sz < 4) begin
          nw.a = wr_addr;
          nw.d = wr_data;
          q.push_back(nw);
          pushed = 1;
        end
        if (wr_level == 3'd4) begin
          full_seen = 1;
          chk("ready_at_full", 32'(wr_ready), 0);
        end
      end
      pix_log[cyc] = pix_data;
      cyc++;
    end
  end

  // One raster cycle. prob<0 leaves the write channel alone; otherwise a held (unaccepted)
  // write stays stable and a new one is offered with probability prob percent.
  task automatic step(input int x, input int y, input int prob);
    xpos = 10'(x);
    ypos = 10'(y);
    if (prob >= 0 && !(wr_valid && !pushed)) begin
      if (int'($urandom_range(0, 99)) < prob) begin
        wr_valid = 1'b1;
        if ($urandom_range(0, 99) < 3) wr_addr = 17'($urandom_range(FB_SIZE, 131071));
        else                           wr_addr = 17'($urandom_range(0, FB_SIZE - 1));
        wr_data = 24'($urandom);
      end else begin
        wr_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int a, input logic [DW-1:0] d, input int x, input int y);
    bit ok;
    ok = 0;
    wr_valid = 1'b1;
    wr_addr  = 17'(a);
    wr_data  = d;
    for (int i = 0; i < 20; i++) begin
      step(x, y, -1);
      if (pushed) begin
        ok = 1;
        break;
      end
    end
    wr_valid = 1'b0;
    chk("push_accept", 32'(ok), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c640, we0;
    int lines [9] = '{2, 3, 100, 101, 478, 479, 480, 524, 0};
    run = 0; reset = 1'b0; xpos = 10'd700; ypos = 10'd500;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    n_cmp = 0; n_bad = 0; we_cnt = 0; m_err = 0; pushed = 0; full_seen = 0;
    for (int i = 0; i < 131072; i++) sram[i] = 24'($urandom);
    sram[0] = 24'h112233;
    sram[1] = 24'h445566;
    for (int i = 0; i < FB_SIZE; i++) fb[i] = sram[i];
    run = 1;

    // Reset state
    repeat (3) step(700, 500, 0);
    chk("init_level", 32'(wr_level), 0);
    chk("init_ready", 32'(wr_ready), 1);
    chk("init_pix", 32'(pix_data), 0);
    chk("init_err", 32'(wr_err), 0);
    reset = 1'b1;
    repeat (2) step(700, 500, 0);

    // 2x2 doubling on lines 0 and 1
    for (int ln = 0; ln < 2; ln++) begin
      c0 = cyc;
      for (int x = 0; x < 8; x++) step(x, ln, 0);
      step(700, ln, 0);
      step(700, ln, 0);
      chk("dbl_px0", 32'(pix_log[c0 + 2]), 32'h112233);
      chk("dbl_px1", 32'(pix_log[c0 + 3]), 32'h112233);
      chk("dbl_px2", 32'(pix_log[c0 + 4]), 32'h445566);
      chk("dbl_px3", 32'(pix_log[c0 + 5]), 32'h445566);
    end

    // Back-to-back writes in the active area fill the FIFO
    for (int x = 0; x < 20; x++) step(x, 10, 100);
    chk("full_seen", 32'(full_seen), 1);

    // Blanking: drain one per cycle, then steady push+pop at level 1
    repeat (8) step(700, 10, 0);
    chk("blank_drained", 32'(wr_level), 0);
    repeat (8) step(700, 10, 100);
    chk("blank_level_steady", 32'(wr_level), 1);
    repeat (4) step(700, 10, 0);
    chk("blank_empty", 32'(wr_level), 0);

    // Out-of-range write is dropped and flagged; the next one goes through
    push1(76800, 24'h0badad, 700, 500);
    push1(5, 24'habcdef, 700, 500);
    repeat (3) step(700, 500, 0);
    chk("err_sticky", 32'(wr_err), 1);
    chk("addr5_written", 32'(sram[5]), 32'habcdef);
    chk("addr5_model", 32'(fb[5]), 32'habcdef);

    // Right and bottom edge of the visible area
    c640 = 0;
    for (int x = 630; x < 800; x++) begin
      if (x == 640) c640 = cyc;
      step(x, 479, 30);
    end
    for (int x = 0; x < 21; x++) step(x, 480, 30);
    chk("edge_pix_off", 32'(pix_log[c640 + 2]), 0);

    // Randomized raster lines with random writes
    foreach (lines[i]) begin
      for (int x = 0; x < 800; x++) step(x, lines[i], 40);
    end
    chk("err_kept", 32'(wr_err), 1);

    // Reset with three writes queued behind a display-only position
    repeat (8) step(700, 500, 0);
    for (int i = 0; i < 3; i++) push1(100 + i, 24'(32'h10 + i), 2, 2);
    chk("q3_level", 32'(wr_level), 3);
    reset = 1'b0;
    #1;
    chk("midrst_level", 32'(wr_level), 0);
    chk("midrst_ready", 32'(wr_ready), 1);
    chk("midrst_pix", 32'(pix_data), 0);
    chk("midrst_err", 32'(wr_err), 0);
    step(700, 500, 0);
    step(700, 500, 0);
    reset = 1'b1;
    we0 = we_cnt;
    repeat (10) step(700, 500, 0);
    chk("no_we_after_rst", 32'(we_cnt - we0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
